// File: rtl/sync_tx_feeder.sv
// sync_tx_feeder: FIFO-buffered source for the sync_multi req/ack handshake.
// Runs in clk_tx; ack arrives already synchronized.
module sync_tx_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_tx,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic [ADDR_W:0]       count,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_v,
   input  logic                  ack,
   output logic                  busy,
   output logic [1:0]            err
);

   typedef enum logic [1:0] {IDLE, REQ, RTZ} state_t;

   localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   ONE_C = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ONE_P = ADDR_W'(1);
   localparam logic [15:0]       TMO   = 16'(TIMEOUT);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
   logic [ADDR_W-1:0]     wr_ptr_n, rd_ptr_n;
   logic [ADDR_W:0]       count_n;
   logic                  full_n;
   state_t                state, state_n;
   logic [DATA_WIDTH-1:0] tx_data_n;
   logic                  tx_v_n;
   logic [15:0]           tmo_cnt, tmo_n;
   logic [1:0]            err_n;
   logic                  push, pop;

   // full is registered, so a same-cycle pop never frees room for a write
   assign push = wr_en && !full;
   assign busy = (state != IDLE);

   // handshake next-state and registered-output values
   always_comb begin
      state_n   = state;
      tx_v_n    = tx_v;
      tx_data_n = tx_data;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            // a stale high ack (e.g. left over from before reset) blocks a new request
            if (count != '0 && !ack) begin
               tx_data_n = mem[rd_ptr];
               tx_v_n    = 1'b1;
               state_n   = REQ;
            end
         end
         REQ: begin
            if (ack) begin
               tx_v_n  = 1'b0;
               pop     = 1'b1;
               state_n = RTZ;
            end
         end
         RTZ: begin
            if (!ack) state_n = IDLE;
         end
         default: begin
            tx_v_n  = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   // FIFO bookkeeping, phase timer and sticky error flags
   always_comb begin
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      count_n  = count;
      tmo_n    = tmo_cnt;
      err_n    = err;
      if (push) wr_ptr_n = wr_ptr + ONE_P;
      if (pop)  rd_ptr_n = rd_ptr + ONE_P;
      if (push && !pop)      count_n = count + ONE_C;
      else if (pop && !push) count_n = count - ONE_C;
      full_n = (count_n == DEPTH);
      if (wr_en && full) err_n[0] = 1'b1;
      if (state_n != state || state == IDLE) begin
         tmo_n = '0;
      end else begin
         if (tmo_cnt != 16'hFFFF) tmo_n = tmo_cnt + 16'd1;
         // the protocol is never aborted; only the flag is raised
         if (TMO != 16'd0 && tmo_n >= TMO) err_n[1] = 1'b1;
      end
   end

   // FSM state and handshake outputs
   always_ff @(posedge clk_tx) begin
      if (!reset) begin
         state   <= IDLE;
         tx_v    <= 1'b0;
         tx_data <= '0;
      end else begin
         state   <= state_n;
         tx_v    <= tx_v_n;
         tx_data <= tx_data_n;
      end
   end

   // FIFO pointers, occupancy, timer and errors
   always_ff @(posedge clk_tx) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         full    <= 1'b0;
         tmo_cnt <= '0;
         err     <= '0;
      end else begin
         wr_ptr  <= wr_ptr_n;
         rd_ptr  <= rd_ptr_n;
         count   <= count_n;
         full    <= full_n;
         tmo_cnt <= tmo_n;
         err     <= err_n;
      end
   end

   // FIFO storage; contents need no reset since the pointers are cleared
   always_ff @(posedge clk_tx) begin
      if (reset && push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: tb/tb_sync_tx_feeder.sv
// tb_sync_tx_feeder: directed checks of the FIFO-fed req/ack source.
// Ack is driven by hand or by a delayed echo of tx_v.
module tb_sync_tx_feeder;

   logic       clk_tx  = 1'b0;
   logic       reset   = 1'b0;
   logic [7:0] wr_data = '0;
   logic       wr_en   = 1'b0;
   logic       full;
   logic [2:0] count;
   logic [7:0] tx_data;
   logic       tx_v;
   logic       ack;
   logic       busy;
   logic [1:0] err;

   logic       auto_ack = 1'b0;
   logic       ack_man  = 1'b0;
   logic [2:0] dly_sel  = 3'd0;
   logic [7:0] sh       = '0;
   logic       mon_en   = 1'b0;
   logic [7:0] rx_q [$];
   logic [7:0] w6 [8];

   int n_chk  = 0;
   int n_pass = 0;

   sync_tx_feeder #(
      .DATA_WIDTH (8),
      .FIFO_DEPTH (4),
      .ADDR_W     (2),
      .TIMEOUT    (8)
   ) dut (
      .clk_tx  (clk_tx),
      .reset   (reset),
      .wr_data (wr_data),
      .wr_en   (wr_en),
      .full    (full),
      .count   (count),
      .tx_data (tx_data),
      .tx_v    (tx_v),
      .ack     (ack),
      .busy    (busy),
      .err     (err)
   );

   always #5 clk_tx = ~clk_tx;

   // receiver model: ack echoes tx_v after dly_sel+1 cycles
   assign ack = auto_ack ? sh[dly_sel] : ack_man;

   always @(posedge clk_tx) sh <= {sh[6:0], tx_v};

   // capture each word at the edge where the request is acknowledged
   always @(posedge clk_tx) begin
      if (mon_en && tx_v && ack) rx_q.push_back(tx_data);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_tx);
         #1;
      end
   endtask

   task automatic wait_v(input logic lvl, input string tag);
      int k = 0;
      while (tx_v !== lvl && k < 100) begin
         tick();
         k++;
      end
      if (tx_v !== lvl) chk(tag, 32'(tx_v), 32'(lvl));
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < 100) begin
         tick();
         k++;
      end
      if (busy !== 1'b0) chk(tag, 32'(busy), 0);
   endtask

   initial begin
      logic [7:0] exp3 [4];
      int k;
      exp3 = '{8'h01, 8'h02, 8'h03, 8'h04};

      // 1: reset
      tick(2);
      chk("rst tx_v", 32'(tx_v), 0);
      chk("rst count", 32'(count), 0);
      chk("rst err", 32'(err), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst full", 32'(full), 0);
      chk("rst data", 32'(tx_data), 0);
      reset = 1'b1;

      // 2: single word, manual ack
      wr_data = 8'hA5;
      wr_en   = 1'b1;
      tick();
      wr_en = 1'b0;
      chk("t2 count1", 32'(count), 1);
      chk("t2 v early", 32'(tx_v), 0);
      tick();
      chk("t2 v rise", 32'(tx_v), 1);
      chk("t2 data", 32'(tx_data), 'hA5);
      chk("t2 busy", 32'(busy), 1);
      tick(2);
      chk("t2 v hold", 32'(tx_v), 1);
      chk("t2 data hold", 32'(tx_data), 'hA5);
      ack_man = 1'b1;
      tick();
      chk("t2 v fall", 32'(tx_v), 0);
      chk("t2 count0", 32'(count), 0);
      tick(2);
      chk("t2 rtz data", 32'(tx_data), 'hA5);
      chk("t2 rtz busy", 32'(busy), 1);
      ack_man = 1'b0;
      tick();
      chk("t2 idle", 32'(busy), 0);
      chk("t2 err", 32'(err), 0);

      // 3: fill FIFO, overflow, in-order drain with pointer wrap
      for (int i = 0; i < 4; i++) begin
         wr_data = 8'(i + 1);
         wr_en   = 1'b1;
         tick();
      end
      chk("t3 full", 32'(full), 1);
      chk("t3 count4", 32'(count), 4);
      wr_data = 8'h05;
      tick();
      wr_en = 1'b0;
      chk("t3 err0", 32'(err), 1);
      chk("t3 count kept", 32'(count), 4);
      dly_sel  = 3'd0;
      auto_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            wait_v(1'b0, "t3 fall tmo");
            wait_v(1'b1, "t3 rise tmo");
         end
         chk($sformatf("t3 word%0d", i), 32'(tx_data), 32'(exp3[i]));
      end
      wait_v(1'b0, "t3 last fall tmo");
      wait_idle("t3 idle tmo");
      chk("t3 drained", 32'(count), 0);
      chk("t3 not full", 32'(full), 0);

      // 4: handshake timeout at 8 cycles in REQ
      auto_ack = 1'b0;
      ack_man  = 1'b0;
      tick(2);
      wr_data = 8'h3C;
      wr_en   = 1'b1;
      tick();
      wr_en = 1'b0;
      tick();
      chk("t4 req", 32'(tx_v), 1);
      tick(7);
      chk("t4 err1 pre", 32'(err[1]), 0);
      tick();
      chk("t4 err1", 32'(err[1]), 1);
      chk("t4 v held", 32'(tx_v), 1);
      chk("t4 data", 32'(tx_data), 'h3C);
      ack_man = 1'b1;
      tick();
      chk("t4 v fall", 32'(tx_v), 0);
      chk("t4 count0", 32'(count), 0);
      ack_man = 1'b0;
      tick();
      chk("t4 idle", 32'(busy), 0);
      chk("t4 err", 32'(err), 3);

      // 5: reset mid-handshake with ack stuck high
      wr_data = 8'h77;
      wr_en   = 1'b1;
      tick();
      wr_en = 1'b0;
      tick();
      chk("t5 req", 32'(tx_v), 1);
      ack_man = 1'b1;
      reset   = 1'b0;
      tick();
      chk("t5 rst v", 32'(tx_v), 0);
      chk("t5 rst count", 32'(count), 0);
      chk("t5 rst err", 32'(err), 0);
      chk("t5 rst busy", 32'(busy), 0);
      reset   = 1'b1;
      wr_data = 8'h88;
      wr_en   = 1'b1;
      tick();
      wr_en = 1'b0;
      tick(3);
      chk("t5 stale v", 32'(tx_v), 0);
      chk("t5 stale busy", 32'(busy), 0);
      chk("t5 count1", 32'(count), 1);
      ack_man = 1'b0;
      tick();
      chk("t5 v rise", 32'(tx_v), 1);
      chk("t5 data", 32'(tx_data), 'h88);
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      tick();
      chk("t5 idle", 32'(busy), 0);

      // 6: slow receiver, 8 random words in order
      dly_sel  = 3'd5;
      auto_ack = 1'b1;
      mon_en   = 1'b1;
      for (int i = 0; i < 8; i++) w6[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         k = 0;
         while (full && k < 200) begin
            tick();
            k++;
         end
         wr_data = w6[i];
         wr_en   = 1'b1;
         tick();
         wr_en = 1'b0;
      end
      k = 0;
      while (rx_q.size() < 8 && k < 1000) begin
         tick();
         k++;
      end
      chk("t6 rx count", 32'(rx_q.size()), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < rx_q.size())
            chk($sformatf("t6 word%0d", i), 32'(rx_q[i]), 32'(w6[i]));
      end
      wait_idle("t6 idle tmo");
      chk("t6 count0", 32'(count), 0);
      chk("t6 err", 32'(err), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
